// File: rtl/segment_sequencer.sv
// segment_sequencer: runs a queue of (duration, bank) segments for the oscillator bank.
// Each segment is one LOAD cycle followed by (duration+1) RUN cycles. A DONE pulse
// follows the last segment. abort flushes the queue and returns to idle at once.
// Optional feature: define SEG_LOOP_EN to add a loop_en input. While loop_en is high,
// each popped segment is recirculated to the tail.
module segment_sequencer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned BANK_W = 2,
  parameter int unsigned TIME_W = 16
) (
  input  logic                       clk1,
  input  logic                       rst_n,
  input  logic                       seg_wr,
  input  logic [TIME_W-1:0]          seg_time,
  input  logic [BANK_W-1:0]          seg_bank,
  input  logic                       arm,
  input  logic                       abort,
`ifdef SEG_LOOP_EN
  input  logic                       loop_en,
`endif
  output logic                       queue_full,
  output logic                       queue_empty,
  output logic [$clog2(DEPTH):0]     queue_count,
  output logic                       overflow,
  output logic                       load_strobe,
  output logic [BANK_W-1:0]          bank_sel,
  output logic                       running,
  output logic [TIME_W-1:0]          cur_time,
  output logic                       finished
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [TIME_W-1:0] t;
    logic [BANK_W-1:0] b;
  } seg_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  seg_t              r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_load_strobe;
  logic [BANK_W-1:0] r_bank_sel;
  logic              r_running;
  logic [TIME_W-1:0] r_cur_time;
  logic              r_finished;

  seg_t              w_head;
  seg_t              w_host;
  seg_t              w_next_head;
  seg_t              w_load_val;
  logic              w_do_load;
  logic              w_seg_end;
  logic              w_pop;
  logic              w_recirc;
  logic              w_push_ok;
  logic              w_overflow;
  logic              w_more;
  logic [CNT_W-1:0]  w_count_base;
  logic [CNT_W-1:0]  w_count_nxt;

  assign w_head    = r_mem[r_rd_ptr];
  assign w_host    = '{t: seg_time, b: seg_bank};
  assign w_seg_end = (r_state == S_RUN) && (r_cur_time == '0);
  assign w_pop     = w_seg_end && !abort;
`ifdef SEG_LOOP_EN
  assign w_recirc  = w_pop && loop_en;
`else
  assign w_recirc  = 1'b0;
`endif

  // Queue bookkeeping: the pop and the recirculation are applied before the host push is judged.
  always_comb begin
    w_count_base = r_count - CNT_W'(w_pop) + CNT_W'(w_recirc);
    w_push_ok    = seg_wr && !abort && (w_count_base < CNT_W'(DEPTH));
    w_overflow   = seg_wr && !abort && !(w_count_base < CNT_W'(DEPTH));
    w_count_nxt  = w_count_base + CNT_W'(w_push_ok);
    // The head after a pop is forwarded from the same-cycle write when the popped entry was the only one.
    if (r_count > CNT_W'(1)) begin
      w_next_head = r_mem[r_rd_ptr + PTR_W'(1)];
    end else if (w_recirc) begin
      w_next_head = w_head;
    end else begin
      w_next_head = w_host;
    end
    w_more = (r_count > CNT_W'(1)) || w_recirc || w_push_ok;
  end

  // Next-state and segment-load selection.
  always_comb begin
    w_state_nxt = r_state;
    w_do_load   = 1'b0;
    w_load_val  = w_head;
    case (r_state)
      S_IDLE: begin
        if (arm && (r_count != '0)) begin
          w_state_nxt = S_LOAD;
          w_do_load   = 1'b1;
          w_load_val  = w_head;
        end
      end
      S_LOAD: w_state_nxt = S_RUN;
      S_RUN: begin
        if (r_cur_time == '0) begin
          if (w_more) begin
            w_state_nxt = S_LOAD;
            w_do_load   = 1'b1;
            w_load_val  = w_next_head;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_do_load   = 1'b0;
    end
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_load_strobe <= 1'b0;
      r_bank_sel    <= '0;
      r_running     <= 1'b0;
      r_cur_time    <= '0;
      r_finished    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_overflow    <= w_overflow;
      r_load_strobe <= (w_state_nxt == S_LOAD);
      r_running     <= (w_state_nxt == S_RUN);
      r_finished    <= (w_state_nxt == S_DONE);
      if (abort) begin
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
        r_cur_time <= '0;
      end else begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
        r_wr_ptr <= r_wr_ptr + PTR_W'(w_recirc) + PTR_W'(w_push_ok);
        r_count  <= w_count_nxt;
        if (w_do_load) begin
          r_cur_time <= w_load_val.t;
        end else if ((r_state == S_RUN) && (r_cur_time != '0)) begin
          r_cur_time <= r_cur_time - TIME_W'(1);
        end else if (w_state_nxt == S_DONE) begin
          r_cur_time <= '0;
        end
      end
      if (w_do_load) begin
        r_bank_sel <= w_load_val.b;
      end
    end
  end

  // Queue storage: the recirculated entry lands at the tail, a host push right behind it.
  always_ff @(posedge clk1) begin
    if (w_recirc) begin
      r_mem[r_wr_ptr] <= w_head;
    end
    if (w_push_ok) begin
      r_mem[r_wr_ptr + PTR_W'(w_recirc)] <= w_host;
    end
  end

  assign queue_full  = (r_count == CNT_W'(DEPTH));
  assign queue_empty = (r_count == '0);
  assign queue_count = r_count;
  assign overflow    = r_overflow;
  assign load_strobe = r_load_strobe;
  assign bank_sel    = r_bank_sel;
  assign running     = r_running;
  assign cur_time    = r_cur_time;
  assign finished    = r_finished;

endmodule

// File: tb/tb_segment_sequencer.sv
// Testbench for segment_sequencer. The reference model tracks a queue of segments
// and the position within the current segment.
module tb_segment_sequencer;

  localparam int DEPTH  = 8;
  localparam int BANK_W = 2;
  localparam int TIME_W = 16;

  logic                   clk1 = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   seg_wr = 1'b0;
  logic [TIME_W-1:0]      seg_time = '0;
  logic [BANK_W-1:0]      seg_bank = '0;
  logic                   arm = 1'b0;
  logic                   abort = 1'b0;
  logic                   loop_en = 1'b0;
  logic                   queue_full, queue_empty, overflow, load_strobe;
  logic                   running, finished;
  logic [$clog2(DEPTH):0] queue_count;
  logic [BANK_W-1:0]      bank_sel;
  logic [TIME_W-1:0]      cur_time;

  segment_sequencer #(.DEPTH(DEPTH), .BANK_W(BANK_W), .TIME_W(TIME_W)) dut (
    .clk1(clk1), .rst_n(rst_n), .seg_wr(seg_wr), .seg_time(seg_time),
    .seg_bank(seg_bank), .arm(arm), .abort(abort),
`ifdef SEG_LOOP_EN
    .loop_en(loop_en),
`endif
    .queue_full(queue_full), .queue_empty(queue_empty), .queue_count(queue_count),
    .overflow(overflow), .load_strobe(load_strobe), .bank_sel(bank_sel),
    .running(running), .cur_time(cur_time), .finished(finished)
  );

  always #5 clk1 = ~clk1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the queue contents, the position within the current segment
  // (-1 when no segment is active; 0 is the load cycle; 1..t+1 are the run cycles),
  // and a flag for the completion cycle.
  typedef struct { int t; int b; } ent_t;
  ent_t q[$];
  int   m_pos  = -1;
  int   m_t    = 0;
  int   m_b    = 0;
  bit   m_done = 0;
  bit   m_ovf  = 0;
  bit   loop_cfg = 0;

  task automatic model_reset();
    q.delete(); m_pos = -1; m_t = 0; m_b = 0; m_done = 0; m_ovf = 0;
  endtask

  task automatic model_start();
    m_pos = 0; m_t = q[0].t; m_b = q[0].b;
  endtask

  task automatic model_step(input bit wr, input int t, input int b, input bit a,
                            input bit ab, input bit lp);
    bit   seg_over, was_idle;
    int   pre;
    ent_t e;
    if (ab) begin
      q.delete(); m_pos = -1; m_done = 0; m_ovf = 0;
      return;
    end
    pre      = q.size();
    was_idle = (m_pos < 0) && !m_done;
    seg_over = (m_pos >= 0) && (m_pos == m_t + 1);
    m_ovf    = 0;
    m_done   = 0;
    if (seg_over) begin
      e = q.pop_front();
      if (lp) q.push_back(e);
    end
    if (wr) begin
      if (q.size() < DEPTH) begin
        e.t = t; e.b = b;
        q.push_back(e);
      end else begin
        m_ovf = 1;
      end
    end
    if (seg_over) begin
      if (q.size() > 0) model_start();
      else begin m_pos = -1; m_done = 1; end
    end else if (m_pos >= 0) begin
      m_pos++;
    end else if (was_idle && a && pre > 0) begin
      model_start();
    end
  endtask

  task automatic compare_all();
    int exp_ct;
    exp_ct = (m_pos < 0) ? 0 : (m_pos == 0) ? m_t : m_t - (m_pos - 1);
    check("load_strobe", load_strobe, (m_pos == 0));
    check("running",     running,     (m_pos >= 1));
    check("cur_time",    cur_time,    exp_ct);
    check("bank_sel",    bank_sel,    m_b);
    check("finished",    finished,    m_done);
    check("overflow",    overflow,    m_ovf);
    check("queue_count", queue_count, q.size());
    check("queue_full",  queue_full,  (q.size() == DEPTH));
    check("queue_empty", queue_empty, (q.size() == 0));
  endtask

  // One clock: compare at the falling edge, then drive inputs for the next rising edge.
  task automatic tick(input bit wr, input int t, input int b, input bit a, input bit ab);
    @(negedge clk1);
    compare_all();
    seg_wr = wr; seg_time = TIME_W'(t); seg_bank = BANK_W'(b);
    arm = a; abort = ab; loop_en = loop_cfg;
    model_step(wr, t, b, a, ab, loop_cfg);
  endtask

  task automatic apply_reset();
    @(negedge clk1);
    seg_wr = 0; arm = 0; abort = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((m_pos >= 0 || m_done) && n < budget) begin
      tick(0, 0, 0, 0, 0);
      n++;
    end
    check("idle_timeout", n, (n < budget) ? n : -1);
  endtask

  int  seen_pop;
  bit  pushed;

  initial begin
    // Reset values.
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    #10 rst_n = 1'b1;
    repeat (10) tick(0, 0, 0, 0, 0);

    // Two segments, then completion.
    tick(1, 3, 1, 0, 0);
    tick(1, 0, 2, 0, 0);
    tick(0, 0, 0, 1, 0);
    run_until_idle(40);
    repeat (2) tick(0, 0, 0, 0, 0);

    // Fill past capacity, then flush.
    for (int i = 0; i <= DEPTH; i++) tick(1, i, i % 4, 0, 0);
    repeat (2) tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    repeat (2) tick(0, 0, 0, 0, 0);

    // Arm on an empty queue, then abort a long segment (push in abort cycle dropped).
    tick(0, 0, 0, 1, 0);
    repeat (3) tick(0, 0, 0, 0, 0);
    tick(1, 100, 3, 0, 0);
    tick(0, 0, 0, 1, 0);
    repeat (20) tick(0, 0, 0, 0, 0);
    tick(1, 5, 1, 0, 1);
    repeat (3) tick(0, 0, 0, 0, 0);

    // Push exactly at the popping cycle of the last segment.
    tick(1, 2, 3, 0, 0);
    tick(0, 0, 0, 1, 0);
    pushed = 0;
    for (int i = 0; i < 20 && !pushed; i++) begin
      seen_pop = (m_pos >= 0 && m_pos == m_t + 1);
      tick(seen_pop != 0, 1, 2, 0, 0);
      if (seen_pop != 0) pushed = 1;
    end
    run_until_idle(40);

`ifdef SEG_LOOP_EN
    // Recirculating loop over two entries, then drain.
    loop_cfg = 1;
    tick(1, 1, 0, 0, 0);
    tick(1, 2, 1, 0, 0);
    tick(0, 0, 0, 1, 0);
    repeat (30) tick(0, 0, 0, 0, 0);
    loop_cfg = 0;
    run_until_idle(40);
`endif

    // Randomized traffic with occasional abort and asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        apply_reset();
      end else begin
`ifdef SEG_LOOP_EN
        if ($urandom_range(0, 49) == 0) loop_cfg = !loop_cfg;
`endif
        tick($urandom_range(0, 9) < 3, $urandom_range(0, 4), $urandom_range(0, 3),
             $urandom_range(0, 9) == 0, $urandom_range(0, 149) == 0);
      end
    end
    loop_cfg = 0;
    run_until_idle(200);
    tick(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
